// File: rtl/player_engine_if.sv
// player_engine_if
//   Bundles the per-frame game inputs and the renderer/HUD outputs of the
//   CrossyRobbers player controller. FrameClk and Reset are not part of the
//   bundle; they stay plain ports on the engine.
//
//   Inputs to the engine (driven by the game logic, modport master):
//     SpawnEnable, FaceLeftInit, Dir[3:0] {Left,Right,Up,Down}, Speed[2:0],
//     PlayerHit, CollectVal[VAL_W-1:0], Deposit
//   Outputs from the engine (modport slave drives them):
//     Dead, Full, Invuln, State[2:0], Tile[TILE_W-1:0], FaceLeft,
//     Items[clog2(MAX_ITEMS+1)-1:0], Score[SCORE_W-1:0], PlayerX/PlayerY[9:0]
//
//   All signals are sampled and updated once per FrameClk edge; there is no
//   valid/ready pairing because every input is a per-frame level or strobe.
interface player_engine_if #(
    parameter int MAX_ITEMS = 3,
    parameter int VAL_W     = 2,
    parameter int SCORE_W   = 7,
    parameter int TILE_W    = 7
);
    localparam int ITEM_W = $clog2(MAX_ITEMS + 1);

    // game logic -> engine
    logic              SpawnEnable;
    logic              FaceLeftInit;
    logic [3:0]        Dir;
    logic [2:0]        Speed;
    logic              PlayerHit;
    logic [VAL_W-1:0]  CollectVal;
    logic              Deposit;

    // engine -> renderer / HUD
    logic              Dead;
    logic              Full;
    logic              Invuln;
    logic [2:0]        State;
    logic [TILE_W-1:0] Tile;
    logic              FaceLeft;
    logic [ITEM_W-1:0] Items;
    logic [SCORE_W-1:0] Score;
    logic [9:0]        PlayerX;
    logic [9:0]        PlayerY;

    modport master (
        output SpawnEnable, FaceLeftInit, Dir, Speed, PlayerHit, CollectVal, Deposit,
        input  Dead, Full, Invuln, State, Tile, FaceLeft, Items, Score, PlayerX, PlayerY
    );

    modport slave (
        input  SpawnEnable, FaceLeftInit, Dir, Speed, PlayerHit, CollectVal, Deposit,
        output Dead, Full, Invuln, State, Tile, FaceLeft, Items, Score, PlayerX, PlayerY
    );
endinterface

// File: rtl/player_engine.sv
// player_engine
//   Per-frame player controller: spawn, clamped movement, item carrying,
//   banking at the deposit zone, death animation, death penalty, respawn.
//
//   Ports:
//     FrameClk  - one rising edge per video frame
//     Reset     - asynchronous, active-high; returns everything to spawn values
//     pif       - player_engine_if.slave (game inputs in, render/HUD out)
//
//   State encoding (visible on pif.State for debug and checking):
//     Spawn=0, Idle=1, Walk=2, Dying=3, Penalty=4
//
//   Optional feature macro: PLAYER_GRACE_EN
//     defined   - GRACE_FRAMES frames of post-respawn invulnerability
//     undefined - no grace window, Invuln is always 0
module player_engine #(
    parameter int MAX_ITEMS       = 3,
    parameter int TILES_PER_ANIM  = 8,
    parameter int FRAMES_PER_TILE = 5,
    parameter int DEATH_TICKS     = 60,
    parameter int MOVE_DIV        = 2,
    parameter int GRACE_FRAMES    = 120,
    parameter int P_W             = 32,
    parameter int P_H             = 32,
    parameter int MIN_X           = 100,
    parameter int MAX_X           = 739,
    parameter int MIN_Y           = 65,
    parameter int MAX_Y           = 448,
    parameter int SPAWN_X         = 292,
    parameter int SPAWN_Y         = 400,
    parameter int VAL_W           = 2,
    parameter int SCORE_W         = 7,
    parameter int TILE_W          = 7
) (
    input  logic            FrameClk,
    input  logic            Reset,
    player_engine_if.slave  pif
);

    localparam int ITEM_W = $clog2(MAX_ITEMS + 1);
    localparam int VSUM_W = $clog2(MAX_ITEMS * ((1 << VAL_W) - 1) + 1);
    localparam int SUM_W  = SCORE_W + VSUM_W;
    localparam int FR_W   = (FRAMES_PER_TILE > 1) ? $clog2(FRAMES_PER_TILE) : 1;
    localparam int TL_W   = (TILES_PER_ANIM > 1)  ? $clog2(TILES_PER_ANIM)  : 1;
    localparam int MV_W   = (MOVE_DIV > 1)        ? $clog2(MOVE_DIV)        : 1;
    localparam int DT_W   = (DEATH_TICKS > 1)     ? $clog2(DEATH_TICKS)     : 1;
    localparam int GR_W   = $clog2(GRACE_FRAMES + 1);

    typedef enum logic [2:0] {
        S_SPAWN   = 3'd0,
        S_IDLE    = 3'd1,
        S_WALK    = 3'd2,
        S_DYING   = 3'd3,
        S_PENALTY = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [FR_W-1:0]    frame_q;
    logic [TL_W-1:0]    tile_q;
    logic [MV_W-1:0]    move_q;
    logic [DT_W-1:0]    death_q;
    logic [ITEM_W-1:0]  items_q;
    logic [VSUM_W-1:0]  val_q;
    logic [SCORE_W-1:0] score_q;
    logic [9:0]         x_q, y_q;
    logic               face_q;
    logic               invuln;

    // ---------------------------------------------------------------
    // Per-frame decode
    // ---------------------------------------------------------------
    logic active, frame_wrap, tile_wrap, hit_take, move_frame, full, collect;
    logic dying_done, penalty_done;
    logic left, right, up, down, mv_x, mv_y;
    logic [FR_W-1:0] frame_nxt;
    logic [TL_W-1:0] tile_adv;

    assign active       = (state_q == S_IDLE) || (state_q == S_WALK);
    assign frame_wrap   = (frame_q == FR_W'(FRAMES_PER_TILE - 1));
    assign tile_wrap    = (tile_q == TL_W'(TILES_PER_ANIM - 1));
    assign frame_nxt    = frame_wrap ? '0 : frame_q + FR_W'(1);
    assign tile_adv     = !frame_wrap ? tile_q : (tile_wrap ? '0 : tile_q + TL_W'(1));
    // A hit pre-empts everything else on that frame, movement included.
    assign hit_take     = active && pif.PlayerHit && !invuln;
    assign move_frame   = active && (move_q == '0) && !hit_take;
    assign full         = (items_q == ITEM_W'(MAX_ITEMS));
    assign collect      = (pif.CollectVal != '0);
    assign dying_done   = (state_q == S_DYING) && frame_wrap && tile_wrap;
    assign penalty_done = (state_q == S_PENALTY) && frame_wrap &&
                          (death_q == DT_W'(DEATH_TICKS - 1));

    assign left  = pif.Dir[3];
    assign right = pif.Dir[2];
    assign up    = pif.Dir[1];
    assign down  = pif.Dir[0];
    // An axis only moves when exactly one of its two buttons is held.
    assign mv_x  = left ^ right;
    assign mv_y  = up ^ down;

    // ---------------------------------------------------------------
    // Movement: effective speed and clamped candidate positions.
    // 11-bit arithmetic keeps x+P_W+spd from wrapping.
    // ---------------------------------------------------------------
    logic [10:0] spd, x_ext, y_ext;
    logic [9:0]  x_mv, y_mv;

    always_comb begin
        spd = 11'd1;
        if ({8'd0, pif.Speed} > 11'(items_q))
            spd = {8'd0, pif.Speed} - 11'(items_q);
    end

    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};

    always_comb begin
        x_mv = x_q;
        if (left) begin
            if (x_ext >= 11'(MIN_X) + spd) x_mv = 10'(x_ext - spd);
            else                           x_mv = 10'(MIN_X);
        end else if (right) begin
            if (x_ext + 11'(P_W) + spd <= 11'(MAX_X)) x_mv = 10'(x_ext + spd);
            else                                      x_mv = 10'(MAX_X - P_W);
        end
    end

    always_comb begin
        y_mv = y_q;
        if (up) begin
            if (y_ext >= 11'(MIN_Y) + spd) y_mv = 10'(y_ext - spd);
            else                           y_mv = 10'(MIN_Y);
        end else if (down) begin
            if (y_ext + 11'(P_H) + spd <= 11'(MAX_Y)) y_mv = 10'(y_ext + spd);
            else                                      y_mv = 10'(MAX_Y - P_H);
        end
    end

    // Saturating bank of the carried value.
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_bank;
    assign score_sum  = SUM_W'(score_q) + SUM_W'(val_q);
    assign score_bank = (score_sum > SUM_W'((1 << SCORE_W) - 1)) ? '1 : score_sum[SCORE_W-1:0];

    // ---------------------------------------------------------------
    // Grace window
    // ---------------------------------------------------------------
`ifdef PLAYER_GRACE_EN
    logic [GR_W-1:0] grace_q;

    always_ff @(posedge FrameClk or posedge Reset) begin
        if (Reset) begin
            grace_q <= '0;
        end else if (pif.SpawnEnable) begin
            if (state_q == S_SPAWN)
                grace_q <= GR_W'(GRACE_FRAMES);
            else if (active && grace_q != '0)
                grace_q <= grace_q - GR_W'(1);
        end
    end
`else
    // No grace counter in this build; the window is permanently closed.
    logic [GR_W-1:0] grace_q;
    assign grace_q = '0;
`endif
    assign invuln = (grace_q != '0);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge FrameClk or posedge Reset) begin
        if (Reset) state_q <= S_SPAWN;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (!pif.SpawnEnable) begin
            state_d = S_SPAWN;
        end else begin
            case (state_q)
                S_SPAWN: state_d = S_IDLE;
                S_IDLE, S_WALK: begin
                    if (hit_take)        state_d = S_DYING;
                    else if (move_frame) state_d = (mv_x || mv_y) ? S_WALK : S_IDLE;
                end
                S_DYING:   if (dying_done)   state_d = S_PENALTY;
                S_PENALTY: if (penalty_done) state_d = S_SPAWN;
                default:   state_d = S_SPAWN;
            endcase
        end
    end

    // FSM: outputs
    logic [1:0] anim_sel;
    always_comb begin
        case (state_q)
            S_WALK:    anim_sel = 2'd1;
            S_DYING:   anim_sel = 2'd2;
            S_PENALTY: anim_sel = 2'd3;
            default:   anim_sel = 2'd0;
        endcase
        pif.State = state_q;
        pif.Dead  = (state_q == S_DYING) || (state_q == S_PENALTY);
        pif.Tile  = TILE_W'(anim_sel) * TILE_W'(TILES_PER_ANIM * (MAX_ITEMS + 1))
                  + TILE_W'(tile_q) * TILE_W'(MAX_ITEMS + 1)
                  + TILE_W'(items_q);
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge FrameClk or posedge Reset) begin
        if (Reset) begin
            frame_q <= '0;
            tile_q  <= '0;
            move_q  <= '0;
            death_q <= '0;
            items_q <= '0;
            val_q   <= '0;
            score_q <= '0;
            x_q     <= 10'(SPAWN_X);
            y_q     <= 10'(SPAWN_Y);
            face_q  <= 1'b0;
        end else if (!pif.SpawnEnable) begin
            // Game paused: only the score is cleared, everything else holds.
            score_q <= '0;
        end else begin
            case (state_q)
                S_SPAWN: begin
                    x_q     <= 10'(SPAWN_X);
                    y_q     <= 10'(SPAWN_Y);
                    face_q  <= pif.FaceLeftInit;
                    items_q <= '0;
                    val_q   <= '0;
                    frame_q <= '0;
                    tile_q  <= '0;
                    move_q  <= '0;
                    death_q <= '0;
                end
                S_IDLE, S_WALK: begin
                    if (hit_take) begin
                        // Loot is dropped and the death animation starts from tile 0.
                        frame_q <= '0;
                        tile_q  <= '0;
                        death_q <= '0;
                        items_q <= '0;
                        val_q   <= '0;
                    end else begin
                        frame_q <= frame_nxt;
                        tile_q  <= tile_adv;
                        move_q  <= (move_q == MV_W'(MOVE_DIV - 1)) ? '0 : move_q + MV_W'(1);
                        if (move_frame) begin
                            if (mv_x) begin
                                x_q    <= x_mv;
                                face_q <= left;
                            end
                            if (mv_y) y_q <= y_mv;
                        end
                        if (pif.Deposit) begin
                            // Bank first; a same-frame pickup starts the next haul.
                            score_q <= score_bank;
                            if (collect) begin
                                items_q <= ITEM_W'(1);
                                val_q   <= VSUM_W'(pif.CollectVal);
                            end else begin
                                items_q <= '0;
                                val_q   <= '0;
                            end
                        end else if (collect && !full) begin
                            items_q <= items_q + ITEM_W'(1);
                            val_q   <= val_q + VSUM_W'(pif.CollectVal);
                        end
                    end
                end
                S_DYING: begin
                    frame_q <= frame_nxt;
                    // Last tile of the cycle is held for the whole Penalty.
                    if (frame_wrap && !tile_wrap) tile_q <= tile_q + TL_W'(1);
                    death_q <= '0;
                end
                S_PENALTY: begin
                    frame_q <= frame_nxt;
                    if (frame_wrap) death_q <= death_q + DT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign pif.Full     = full;
    assign pif.Invuln   = invuln;
    assign pif.FaceLeft = face_q;
    assign pif.Items    = items_q;
    assign pif.Score    = score_q;
    assign pif.PlayerX  = x_q;
    assign pif.PlayerY  = y_q;

endmodule

// File: tb/tb_player_engine.sv
module tb_player_engine;

    logic FrameClk;
    logic Reset;
    int   n_checks;
    int   n_fail;

    player_engine_if pif ();

    player_engine dut (
        .FrameClk (FrameClk),
        .Reset    (Reset),
        .pif      (pif)
    );

    // ---------------- clock / reset ----------------
    initial FrameClk = 1'b0;
    always #5 FrameClk = ~FrameClk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Advance one frame; inputs change and outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge FrameClk);
        #1;
    endtask

    // Hold a direction for n move frames (MOVE_DIV=2 -> 2n frames).
    task automatic move(input logic [3:0] d, input logic [2:0] s, input int n);
        pif.Dir   = d;
        pif.Speed = s;
        repeat (2 * n) tick();
        pif.Dir   = 4'b0000;
    endtask

    task automatic collect_one(input logic [1:0] v);
        pif.CollectVal = v;
        tick();
        pif.CollectVal = 2'd0;
    endtask

    task automatic deposit_one();
        pif.Deposit = 1'b1;
        tick();
        pif.Deposit = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b1;
        pif.SpawnEnable = 1'b0; pif.FaceLeftInit = 1'b0; pif.Dir = 4'b0000;
        pif.Speed = 3'd0; pif.PlayerHit = 1'b0; pif.CollectVal = 2'd0; pif.Deposit = 1'b0;
        repeat (3) tick();
        n_checks++; if (pif.State !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", pif.State); end
        n_checks++; if (pif.PlayerX !== 10'd292) begin n_fail++; $display("FAIL reset_x: got %0d expected 292", pif.PlayerX); end
        n_checks++; if (pif.PlayerY !== 10'd400) begin n_fail++; $display("FAIL reset_y: got %0d expected 400", pif.PlayerY); end
        n_checks++; if (pif.Score !== 7'd0 || pif.Items !== 2'd0) begin n_fail++; $display("FAIL reset_score_items: got %0d/%0d expected 0/0", pif.Score, pif.Items); end
        n_checks++; if (pif.FaceLeft !== 1'b0 || pif.Dead !== 1'b0 || pif.Invuln !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b%b expected 000", pif.FaceLeft, pif.Dead, pif.Invuln); end
        n_checks++; if (pif.Tile !== 7'd0) begin n_fail++; $display("FAIL reset_tile: got %0d expected 0", pif.Tile); end
    endtask

    task automatic test_spawn_walk();
        Reset = 1'b0;
        pif.SpawnEnable = 1'b1;
        pif.Speed = 3'd4;
        pif.Dir = 4'b1000;
        tick(); // Spawn frame
        n_checks++; if (pif.State !== 3'd1 || pif.PlayerX !== 10'd292) begin n_fail++; $display("FAIL spawn_idle: got state %0d x %0d expected 1 292", pif.State, pif.PlayerX); end
`ifdef PLAYER_GRACE_EN
        n_checks++; if (pif.Invuln !== 1'b1) begin n_fail++; $display("FAIL spawn_invuln: got %0d expected 1", pif.Invuln); end
`endif
        tick();
        n_checks++; if (pif.PlayerX !== 10'd288 || pif.State !== 3'd2 || pif.FaceLeft !== 1'b1) begin n_fail++; $display("FAIL walk_step1: got x %0d state %0d face %0d expected 288 2 1", pif.PlayerX, pif.State, pif.FaceLeft); end
        n_checks++; if (pif.Tile !== 7'd32) begin n_fail++; $display("FAIL walk_tile: got %0d expected 32", pif.Tile); end
        tick();
        n_checks++; if (pif.PlayerX !== 10'd288) begin n_fail++; $display("FAIL walk_hold: got %0d expected 288", pif.PlayerX); end
        tick();
        n_checks++; if (pif.PlayerX !== 10'd284) begin n_fail++; $display("FAIL walk_step2: got %0d expected 284", pif.PlayerX); end
        tick();
        tick();
        n_checks++; if (pif.PlayerX !== 10'd280 || pif.Tile !== 7'd36) begin n_fail++; $display("FAIL walk_tick: got x %0d tile %0d expected 280 36", pif.PlayerX, pif.Tile); end
        pif.Dir = 4'b0000;
    endtask

    task automatic test_clamp();
        move(4'b1000, 3'd7, 25);  // 280 -> 105
        move(4'b1000, 3'd3, 1);   // -> 102
        n_checks++; if (pif.PlayerX !== 10'd102) begin n_fail++; $display("FAIL clamp_pre_left: got %0d expected 102", pif.PlayerX); end
        move(4'b1000, 3'd4, 1);
        n_checks++; if (pif.PlayerX !== 10'd100) begin n_fail++; $display("FAIL clamp_left: got %0d expected 100", pif.PlayerX); end
        move(4'b1000, 3'd4, 1);
        n_checks++; if (pif.PlayerX !== 10'd100) begin n_fail++; $display("FAIL clamp_left_hold: got %0d expected 100", pif.PlayerX); end
        move(4'b0100, 3'd7, 86);  // -> 702
        move(4'b0100, 3'd3, 1);   // -> 705
        n_checks++; if (pif.PlayerX !== 10'd705 || pif.FaceLeft !== 1'b0) begin n_fail++; $display("FAIL clamp_pre_right: got x %0d face %0d expected 705 0", pif.PlayerX, pif.FaceLeft); end
        move(4'b0100, 3'd4, 1);
        n_checks++; if (pif.PlayerX !== 10'd707) begin n_fail++; $display("FAIL clamp_right: got %0d expected 707", pif.PlayerX); end
        move(4'b0100, 3'd4, 1);
        n_checks++; if (pif.PlayerX !== 10'd707) begin n_fail++; $display("FAIL clamp_right_hold: got %0d expected 707", pif.PlayerX); end
        move(4'b0001, 3'd7, 3);   // 400 -> 407 -> 414 -> 416
        n_checks++; if (pif.PlayerY !== 10'd416) begin n_fail++; $display("FAIL clamp_down: got %0d expected 416", pif.PlayerY); end
        move(4'b0010, 3'd7, 1);
        n_checks++; if (pif.PlayerY !== 10'd409) begin n_fail++; $display("FAIL move_up: got %0d expected 409", pif.PlayerY); end
        move(4'b1100, 3'd7, 1);   // opposing buttons cancel
        n_checks++; if (pif.PlayerX !== 10'd707 || pif.State !== 3'd1) begin n_fail++; $display("FAIL cancel_lr: got x %0d state %0d expected 707 1", pif.PlayerX, pif.State); end
    endtask

    task automatic test_collect();
        collect_one(2'd2);
        collect_one(2'd3);
        collect_one(2'd1);
        n_checks++; if (pif.Items !== 2'd3 || pif.Full !== 1'b1) begin n_fail++; $display("FAIL collect_full: got items %0d full %0d expected 3 1", pif.Items, pif.Full); end
        collect_one(2'd2);
        n_checks++; if (pif.Items !== 2'd3) begin n_fail++; $display("FAIL collect_ignored: got %0d expected 3", pif.Items); end
        move(4'b1000, 3'd4, 1);   // speed 4-3 = 1
        n_checks++; if (pif.PlayerX !== 10'd706) begin n_fail++; $display("FAIL loaded_speed: got %0d expected 706", pif.PlayerX); end
        deposit_one();
        n_checks++; if (pif.Score !== 7'd6 || pif.Items !== 2'd0 || pif.Full !== 1'b0) begin n_fail++; $display("FAIL deposit: got score %0d items %0d full %0d expected 6 0 0", pif.Score, pif.Items, pif.Full); end
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 13; r++) begin
            collect_one(2'd3); collect_one(2'd3); collect_one(2'd3);
            deposit_one();
        end
        collect_one(2'd3);
        deposit_one();
        n_checks++; if (pif.Score !== 7'd126) begin n_fail++; $display("FAIL score_126: got %0d expected 126", pif.Score); end
        collect_one(2'd3);
        deposit_one();
        n_checks++; if (pif.Score !== 7'd127) begin n_fail++; $display("FAIL score_sat: got %0d expected 127", pif.Score); end
        pif.SpawnEnable = 1'b0;
        tick();
        n_checks++; if (pif.Score !== 7'd0 || pif.State !== 3'd0) begin n_fail++; $display("FAIL spawn_disable: got score %0d state %0d expected 0 0", pif.Score, pif.State); end
        pif.SpawnEnable = 1'b1;
        tick();
        n_checks++; if (pif.PlayerX !== 10'd292 || pif.PlayerY !== 10'd400 || pif.State !== 3'd1) begin n_fail++; $display("FAIL respawn_pos: got %0d,%0d state %0d expected 292,400 1", pif.PlayerX, pif.PlayerY, pif.State); end
    endtask

    task automatic test_back_to_back();
        collect_one(2'd1);
        pif.CollectVal = 2'd2;
        pif.Deposit = 1'b1;
        tick();
        pif.CollectVal = 2'd0;
        pif.Deposit = 1'b0;
        n_checks++; if (pif.Score !== 7'd1 || pif.Items !== 2'd1) begin n_fail++; $display("FAIL collect_deposit: got score %0d items %0d expected 1 1", pif.Score, pif.Items); end
        deposit_one();
        n_checks++; if (pif.Score !== 7'd3 || pif.Items !== 2'd0) begin n_fail++; $display("FAIL carry_over: got score %0d items %0d expected 3 0", pif.Score, pif.Items); end
    endtask

    task automatic test_death();
        repeat (125) tick();
        collect_one(2'd1);
        collect_one(2'd1);
        n_checks++; if (pif.Items !== 2'd2) begin n_fail++; $display("FAIL pre_hit_items: got %0d expected 2", pif.Items); end
        pif.PlayerHit = 1'b1;
        tick();
        n_checks++; if (pif.Dead !== 1'b1 || pif.Items !== 2'd0 || pif.State !== 3'd3) begin n_fail++; $display("FAIL hit: got dead %0d items %0d state %0d expected 1 0 3", pif.Dead, pif.Items, pif.State); end
        n_checks++; if (pif.Tile !== 7'd64) begin n_fail++; $display("FAIL dying_tile: got %0d expected 64", pif.Tile); end
        repeat (39) tick();
        n_checks++; if (pif.State !== 3'd3) begin n_fail++; $display("FAIL dying_len: got %0d expected 3", pif.State); end
        tick();
        n_checks++; if (pif.State !== 3'd4 || pif.Tile !== 7'd124) begin n_fail++; $display("FAIL penalty_entry: got state %0d tile %0d expected 4 124", pif.State, pif.Tile); end
        pif.PlayerHit = 1'b0;
        repeat (299) tick();
        n_checks++; if (pif.State !== 3'd4 || pif.Dead !== 1'b1) begin n_fail++; $display("FAIL penalty_len: got state %0d dead %0d expected 4 1", pif.State, pif.Dead); end
        tick();
        n_checks++; if (pif.State !== 3'd0) begin n_fail++; $display("FAIL penalty_exit: got %0d expected 0", pif.State); end
        tick();
        n_checks++; if (pif.State !== 3'd1 || pif.PlayerX !== 10'd292 || pif.PlayerY !== 10'd400 || pif.Dead !== 1'b0) begin n_fail++; $display("FAIL respawn: got state %0d pos %0d,%0d dead %0d expected 1 292,400 0", pif.State, pif.PlayerX, pif.PlayerY, pif.Dead); end
    endtask

    task automatic test_grace();
`ifdef PLAYER_GRACE_EN
        repeat (49) tick();
        pif.PlayerHit = 1'b1;
        tick();               // Idle frame 50
        pif.PlayerHit = 1'b0;
        n_checks++; if (pif.State !== 3'd1 || pif.Invuln !== 1'b1) begin n_fail++; $display("FAIL grace_hit50: got state %0d invuln %0d expected 1 1", pif.State, pif.Invuln); end
        repeat (69) tick();   // through frame 119
        n_checks++; if (pif.Invuln !== 1'b1) begin n_fail++; $display("FAIL grace_119: got %0d expected 1", pif.Invuln); end
        tick();               // frame 120
        n_checks++; if (pif.Invuln !== 1'b0) begin n_fail++; $display("FAIL grace_120: got %0d expected 0", pif.Invuln); end
        pif.PlayerHit = 1'b1;
        tick();               // frame 121
        pif.PlayerHit = 1'b0;
        n_checks++; if (pif.State !== 3'd3) begin n_fail++; $display("FAIL grace_hit121: got %0d expected 3", pif.State); end
`else
        pif.PlayerHit = 1'b1;
        tick();               // first Idle frame after spawn
        pif.PlayerHit = 1'b0;
        n_checks++; if (pif.State !== 3'd3 || pif.Dead !== 1'b1 || pif.Invuln !== 1'b0) begin n_fail++; $display("FAIL nograce_hit1: got state %0d dead %0d invuln %0d expected 3 1 0", pif.State, pif.Dead, pif.Invuln); end
`endif
    endtask

    task automatic test_reset_mid_death();
        repeat (3) tick();
        Reset = 1'b1;
        #1;
        n_checks++; if (pif.State !== 3'd0 || pif.Dead !== 1'b0 || pif.Score !== 7'd0) begin n_fail++; $display("FAIL async_reset: got state %0d dead %0d score %0d expected 0 0 0", pif.State, pif.Dead, pif.Score); end
        n_checks++; if (pif.PlayerX !== 10'd292 || pif.PlayerY !== 10'd400 || pif.Tile !== 7'd0) begin n_fail++; $display("FAIL async_reset_pos: got %0d,%0d tile %0d expected 292,400 0", pif.PlayerX, pif.PlayerY, pif.Tile); end
        tick();
        Reset = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_spawn_walk();
        test_clamp();
        test_collect();
        test_saturation();
        test_back_to_back();
        test_death();
        test_grace();
        test_reset_mid_death();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
